// File: rtl/tone_poly.sv
// tone_poly: polyphonic square-wave tone generator.
//   CLK, RST (async, active high)
//   load/ch_sel/period_in/dur_in : program one channel (period us, duration ms)
//   tone_out[NCH]  : registered square wave per channel
//   busy[NCH]      : channel in PLAY
//   done[NCH]      : one-cycle pulse on natural expiry
//   mix_level      : registered popcount of tone_out
// A shared timebase produces a half-microsecond tick and a millisecond tick;
// each channel is a small two-state FSM instantiated once per lane.

// Per-channel FSM: IDLE / PLAY with period counter and duration countdown.
module tone_poly_ch #(
  parameter int PW = 24,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          half_tick,
  input  logic          ms_tick,
  input  logic          hit,
  input  logic [PW-1:0] period_in,
  input  logic [DW-1:0] dur_in,
  output logic          tone,
  output logic          busy,
  output logic          done
);
  typedef enum logic {IDLE, PLAY} state_t;

  state_t        state, state_d;
  logic [PW-1:0] per, per_d, cnt, cnt_d;
  logic [DW-1:0] rem, rem_d;
  logic          tone_d, done_d;

  always_comb begin
    state_d = state;
    per_d   = per;
    cnt_d   = cnt;
    rem_d   = rem;
    tone_d  = tone;
    done_d  = 1'b0;
    if (hit) begin
      // A load always wins, even over an expiry landing in the same cycle.
      if (period_in != '0 && dur_in != '0) begin
        per_d   = period_in;
        rem_d   = dur_in;
        cnt_d   = '0;
        tone_d  = 1'b0;
        state_d = PLAY;
      end else begin
        state_d = IDLE;
        tone_d  = 1'b0;
      end
    end else if (state == PLAY) begin
      if (half_tick) begin
        if (cnt == per - PW'(1)) begin
          cnt_d  = '0;
          tone_d = ~tone;
        end else begin
          cnt_d = cnt + PW'(1);
        end
      end
      // All-ones duration is sustain: never counts down.
      if (ms_tick && rem != '1) begin
        if (rem == DW'(1)) begin
          state_d = IDLE;
          tone_d  = 1'b0;   // overrides a toggle in the same cycle
          done_d  = 1'b1;
        end else begin
          rem_d = rem - DW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      per   <= '0;
      cnt   <= '0;
      rem   <= '0;
      tone  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      per   <= per_d;
      cnt   <= cnt_d;
      rem   <= rem_d;
      tone  <= tone_d;
      done  <= done_d;
    end
  end

  assign busy = (state == PLAY);
endmodule

module tone_poly #(
  parameter int CLK_F = 200,
  parameter int NCH   = 4,
  parameter int PW    = 24,
  parameter int DW    = 16,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int MW   = $clog2(NCH + 1)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           load,
  input  logic [CW-1:0]  ch_sel,
  input  logic [PW-1:0]  period_in,
  input  logic [DW-1:0]  dur_in,
  output logic [NCH-1:0] tone_out,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done,
  output logic [MW-1:0]  mix_level
);
  localparam int PRE_MAX = CLK_F / 2 - 1;
  localparam int PRE_W   = (CLK_F / 2 > 1) ? $clog2(CLK_F / 2) : 1;

  logic [PRE_W-1:0] pre;
  logic [10:0]      ms_cnt;
  logic             half_tick, ms_tick;
  logic [NCH-1:0]   hit;
  logic [MW-1:0]    pc;

  assign half_tick = (pre == PRE_W'(PRE_MAX));
  assign ms_tick   = half_tick && (ms_cnt == 11'd1999);

  // Free-running timebase; load never disturbs it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre    <= '0;
      ms_cnt <= '0;
    end else if (half_tick) begin
      pre    <= '0;
      ms_cnt <= (ms_cnt == 11'd1999) ? 11'd0 : ms_cnt + 11'd1;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      // ch_sel values >= NCH match no lane and are dropped.
      assign hit[i] = load && (ch_sel == CW'(i));
      tone_poly_ch #(.PW(PW), .DW(DW)) u_ch (
        .CLK       (CLK),
        .RST       (RST),
        .half_tick (half_tick),
        .ms_tick   (ms_tick),
        .hit       (hit[i]),
        .period_in (period_in),
        .dur_in    (dur_in),
        .tone      (tone_out[i]),
        .busy      (busy[i]),
        .done      (done[i])
      );
    end
  endgenerate

  always_comb begin
    pc = '0;
    for (int k = 0; k < NCH; k++) pc = pc + MW'(tone_out[k]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) mix_level <= '0;
    else     mix_level <= pc;
  end
endmodule

// File: tb/tb_tone_poly.sv
module tb_tone_poly;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        load = 1'b0, load_b = 1'b0;
  logic [1:0]  ch_sel = '0;
  logic [23:0] period_in = '0;
  logic [15:0] dur_in = '0;
  logic [3:0]  tone_out, busy, done;
  logic [2:0]  mix_level;
  logic [2:0]  tone_b, busy_b, done_b;
  logic [1:0]  mix_b;

  tone_poly #(.CLK_F(4), .NCH(4), .PW(24), .DW(16)) dut (
    .CLK(CLK), .RST(RST), .load(load), .ch_sel(ch_sel), .period_in(period_in),
    .dur_in(dur_in), .tone_out(tone_out), .busy(busy), .done(done), .mix_level(mix_level));

  // Three-channel instance so an out-of-range ch_sel (3) can be driven.
  tone_poly #(.CLK_F(2), .NCH(3), .PW(24), .DW(16)) dut_b (
    .CLK(CLK), .RST(RST), .load(load_b), .ch_sel(ch_sel), .period_in(period_in),
    .dur_in(dur_in), .tone_out(tone_b), .busy(busy_b), .done(done_b), .mix_level(mix_b));

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;
  int cyc;
  logic [3:0] prev_tone;
  int nchg[4], first_chg[4], last_chg[4], exp_ival[4], ival_bad[4], done_cnt[4];
  int mix_bad, mix_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int pop4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  task automatic track_reset(input int ch, input int ival);
    nchg[ch] = 0; first_chg[ch] = 0; ival_bad[ch] = 0; exp_ival[ch] = ival;
  endtask

  // One clock: sample at the falling edge and update the running monitors.
  task automatic step();
    @(negedge CLK);
    cyc++;
    if (mix_level !== 3'(pop4(prev_tone))) mix_bad++;
    if (int'(mix_level) > mix_max) mix_max = int'(mix_level);
    for (int i = 0; i < 4; i++) begin
      if (tone_out[i] !== prev_tone[i]) begin
        if (nchg[i] == 0) first_chg[i] = cyc;
        else if (cyc - last_chg[i] != exp_ival[i]) ival_bad[i]++;
        last_chg[i] = cyc;
        nchg[i]++;
      end
      if (done[i] === 1'b1) done_cnt[i]++;
    end
    prev_tone = tone_out;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic prog(input logic [1:0] ch, input int p, input int d);
    ch_sel = ch; period_in = 24'(p); dur_in = 16'(d); load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    mix_bad = 0; mix_max = 0;
    for (int i = 0; i < 4; i++) begin track_reset(i, 0); done_cnt[i] = 0; end
    repeat (3) @(negedge CLK);
    check("rst_tone", tone_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mix", mix_level, 0);
    RST = 1'b0; cyc = 0; prev_tone = '0;
    exp_ival[0] = 6; exp_ival[1] = 2; exp_ival[2] = 8;

    // ch1: period 1, 2 ms; ch0: period 3 sustain; ch2: period 4 sustain.
    prog(2'd1, 1, 2);
    check("busy_latency", busy, 4'b0010);
    prog(2'd0, 3, 16'hFFFF);
    prog(2'd2, 4, 16'hFFFF);
    check("busy_three", busy, 4'b0111);

    run_until(7999);
    check("ch1_no_early_done", done_cnt[1], 0);
    check("ch1_busy_before_exp", busy[1], 1);
    step();
    check("ch1_done_at_8000", done[1], 1);
    step();
    check("ch1_done_one_cycle", done[1], 0);
    check("ch1_busy_after", busy[1], 0);
    check("ch1_tone_after", tone_out[1], 0);

    run_until(8108);
    check("ch0_first_toggle", first_chg[0], 8);
    check("ch1_first_toggle", first_chg[1], 2);
    check("ch2_first_toggle", first_chg[2], 10);
    check("ch1_toggle_count", nchg[1], 4000);
    check("ch0_interval", ival_bad[0], 0);
    check("ch1_interval", ival_bad[1], 0);
    check("ch2_interval", ival_bad[2], 0);
    check("ch1_done_total", done_cnt[1], 1);
    check("ch2_tone_before_retrig", tone_out[2], 1);

    // Retrigger ch2 mid-note with period 5 on an odd cycle.
    prog(2'd2, 5, 16'hFFFF);
    check("retrig_tone0", tone_out[2], 0);
    check("retrig_busy", busy[2], 1);
    track_reset(2, 10);
    run_until(8130);
    check("retrig_first_toggle", first_chg[2], 8118);
    check("retrig_interval", ival_bad[2], 0);
    check("retrig_no_done", done_cnt[2], 0);

    prog(2'd2, 0, 7);
    check("stop_busy", busy[2], 0);
    check("stop_tone", tone_out[2], 0);
    track_reset(2, 0);

    // ch3: 1 ms note expiring at cycle 12000, reloaded on that exact cycle.
    run_until(8199);
    prog(2'd3, 2, 1);
    check("ch3_busy", busy[3], 1);
    run_until(11999);
    check("ch3_busy_pre_exp", busy[3], 1);
    prog(2'd3, 1, 5);
    check("ch3_collide_done", done[3], 0);
    check("ch3_collide_busy", busy[3], 1);
    check("ch3_collide_tone", tone_out[3], 0);
    step();
    check("ch3_new_tone_12001", tone_out[3], 0);
    step();
    check("ch3_new_tone_12002", tone_out[3], 1);
    step(); step();
    check("ch3_new_tone_12004", tone_out[3], 0);
    run_until(12010);
    check("ch3_done_total", done_cnt[3], 0);
    check("ch2_done_total", done_cnt[2], 0);
    check("ch0_done_total", done_cnt[0], 0);
    check("ch0_busy", busy[0], 1);
    check("ch0_interval_late", ival_bad[0], 0);
    check("mix_tracks_popcount", mix_bad, 0);
    check("mix_max", mix_max, 3);

    // Asynchronous reset between clock edges.
    #2 RST = 1'b1;
    #1;
    check("arst_tone", tone_out, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_mix", mix_level, 0);
    @(negedge CLK);
    RST = 1'b0; cyc = 0; prev_tone = '0; mix_bad = 0;
    track_reset(0, 2);
    prog(2'd0, 1, 16'hFFFF);
    check("post_rst_busy", busy, 4'b0001);
    step();
    check("post_rst_first_toggle", tone_out, 4'b0001);
    run_until(20);
    check("post_rst_idle_others", busy, 4'b0001);
    check("post_rst_interval", ival_bad[0], 0);
    check("post_rst_mix", mix_bad, 0);

    // Out-of-range ch_sel on the 3-channel instance is ignored.
    ch_sel = 2'd3; period_in = 24'd1; dur_in = 16'd5; load_b = 1'b1;
    @(negedge CLK); load_b = 1'b0;
    repeat (4) @(negedge CLK);
    check("oor_busy", busy_b, 0);
    check("oor_tone", tone_b, 0);
    ch_sel = 2'd2; load_b = 1'b1;
    @(negedge CLK); load_b = 1'b0;
    check("inrange_busy", busy_b, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
